// File: rtl/uart_core_pkg.sv
// Shared state encodings for the uart_core transmitter and the uart_rx receiver.
package uart_core_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start/data/stop sampling FSM and the CPU-visible
// receive flags. Bits are sampled at mid-bit using a counter that wraps at DIVIDER-1.
module uart_rx
  import uart_core_pkg::*;
#(
  parameter int DIVIDER = 52
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] q,
  output logic       rxvalid,
  output logic       rxoverr,
  output logic       rxframeer,
  output rx_state_e  dbg_state
);

  localparam int CW = $clog2(DIVIDER);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVIDER / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    q_q, q_d;
  logic          rxvalid_q, rxvalid_d;
  logic          overr_q, overr_d;
  logic          frameer_q, frameer_d;
  logic          rxd_s;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      q_q       <= '0;
      rxvalid_q <= 1'b0;
      overr_q   <= 1'b0;
      frameer_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      prev_q    <= rxd_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      q_q       <= q_d;
      rxvalid_q <= rxvalid_d;
      overr_q   <= overr_d;
      frameer_q <= frameer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    q_d       = q_q;
    rxvalid_d = rxvalid_q & ~rd;
    overr_d   = overr_q & ~rd;
    frameer_d = frameer_q & ~rd;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !rxd_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          // A byte landing together with rd wins: it is valid and not an overrun.
          q_d       = shift_q;
          rxvalid_d = 1'b1;
          frameer_d = ~rxd_s;
          overr_d   = rxvalid_q & ~rd;
          state_d   = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign q         = q_q;
  assign rxvalid   = rxvalid_q;
  assign rxoverr   = overr_q;
  assign rxframeer = frameer_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1/8N2 UART with a fixed DIVIDER clocks per bit. The transmitter lives
// here; the receiver is uart_rx. Strobes wr/rd are one-cycle pulses from the CPU decoder.
module uart_core
  import uart_core_pkg::*;
#(
  parameter int DIVIDER = 52
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] q,
  output logic       rxvalid,
  output logic       txrdy,
  output logic       rxoverr,
  output logic       rxframeer,
  input  logic       nstop,
  output logic       txd,
  input  logic       rxd,
  output tx_state_e  dbg_tx_state,
  output rx_state_e  dbg_rx_state
);

  localparam int CW = $clog2(DIVIDER);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDER - 1);

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_nstop_q, tx_nstop_d;
  logic          txd_q, txd_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_nstop_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_nstop_q <= tx_nstop_d;
      txd_q      <= txd_d;
    end
  end

  // txd is registered and loaded one bit ahead, so each bit starts on the wrap edge.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_nstop_d = tx_nstop_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (wr) begin
          tx_shift_d = d;
          tx_nstop_d = nstop;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          txd_d      = tx_shift_q[0];
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_bit_d   = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          if (tx_nstop_q && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
          else tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign txd          = txd_q;
  assign txrdy        = (tx_state_q == TX_IDLE);
  assign dbg_tx_state = tx_state_q;

  uart_rx #(.DIVIDER(DIVIDER)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rd        (rd),
    .q         (q),
    .rxvalid   (rxvalid),
    .rxoverr   (rxoverr),
    .rxframeer (rxframeer),
    .dbg_state (dbg_rx_state)
  );

endmodule

// File: tb/tb_uart_core.sv
// Directed plus randomized bench for uart_core at DIVIDER=8, with a frame-level model
// of the serial line and an expected-byte queue for received data.
module tb_uart_core;
  import uart_core_pkg::*;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       reset, wr, rd, nstop, rxd, rxd_drv, loop_en;
  logic [7:0] d, q;
  logic       rxvalid, txrdy, rxoverr, rxframeer, txd;
  tx_state_e  dbg_tx_state;
  rx_state_e  dbg_rx_state;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_core #(.DIVIDER(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .d            (d),
    .wr           (wr),
    .rd           (rd),
    .q            (q),
    .rxvalid      (rxvalid),
    .txrdy        (txrdy),
    .rxoverr      (rxoverr),
    .rxframeer    (rxframeer),
    .nstop        (nstop),
    .txd          (txd),
    .rxd          (rxd),
    .dbg_tx_state (dbg_tx_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always_comb rxd = loop_en ? txd : rxd_drv;

  // Serial frame model: bit 0 is the start bit, 1..8 are data LSB first, rest are stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic [7:0] b, input logic ns);
    int guard = 0;
    while (txrdy !== 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    chk("send_txrdy_wait", guard < 400, 1);
    d = b; nstop = ns; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic read_pulse();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic wait_rxvalid(input string tag, input int limit);
    int n = 0;
    while (rxvalid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk(tag, n < limit, 1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_v);
    rxd_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      tick(DIV);
    end
    rxd_drv = stop_v;
    tick(DIV);
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] rb;
    logic       rns;

    reset = 1'b1; wr = 1'b0; rd = 1'b0; d = '0; nstop = 1'b0;
    loop_en = 1'b0; rxd_drv = 1'b1;
    tick(3);
    chk("rst_txd", txd, 1);
    chk("rst_txrdy", txrdy, 1);
    chk("rst_q", q, 0);
    chk("rst_rxvalid", rxvalid, 0);
    chk("rst_rxoverr", rxoverr, 0);
    chk("rst_rxframeer", rxframeer, 0);
    reset = 1'b0;
    tick(2);

    // TX frame shape for 8'hA5, with an ignored wr of 8'h00 in the middle
    send(8'hA5, 1'b0);
    chk("tx_txrdy_low", txrdy, 0);
    n = 0;
    while (txrdy === 1'b0 && n < 200) begin
      chk($sformatf("tx_a5_bit%0d_cyc%0d", n / DIV, n), txd, frame_bit(8'hA5, n / DIV));
      if (n == 20) begin d = 8'h00; wr = 1'b1; end
      tick();
      wr = 1'b0;
      n++;
    end
    chk("tx_txrdy_low_cycles", n, 10 * DIV);
    seen = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (txd !== 1'b1 || txrdy !== 1'b1) seen++;
      tick();
    end
    chk("tx_ignored_wr_idle", seen, 0);

    // loopback single byte
    loop_en = 1'b1;
    tick(4);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b0);
    wait_rxvalid("rx_3c_timeout", 200);
    chk("rx_3c_q", q, exp_q.pop_front());
    chk("rx_3c_overr", rxoverr, 0);
    chk("rx_3c_frameer", rxframeer, 0);
    read_pulse();
    chk("rx_3c_rd_clears", rxvalid, 0);

    // overrun: two bytes without reading
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    n = 0;
    while (txrdy !== 1'b1 && n < 400) begin tick(); n++; end
    tick(3 * DIV);
    void'(exp_q.pop_front());
    chk("ovr_q", q, exp_q.pop_front());
    chk("ovr_valid", rxvalid, 1);
    chk("ovr_flag", rxoverr, 1);
    read_pulse();
    chk("ovr_rd_valid", rxvalid, 0);
    chk("ovr_rd_flag", rxoverr, 0);

    // randomized loopback bytes with random stop count and gaps
    for (int k = 0; k < 6; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rns = 1'($urandom_range(0, 1));
      exp_q.push_back(rb);
      send(rb, rns);
      wait_rxvalid($sformatf("rnd%0d_timeout", k), 200);
      chk($sformatf("rnd%0d_q", k), q, exp_q.pop_front());
      chk($sformatf("rnd%0d_overr", k), rxoverr, 0);
      chk($sformatf("rnd%0d_frameer", k), rxframeer, 0);
      read_pulse();
      tick($urandom_range(0, 5));
    end

    // two stop bits stretch the busy time
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1);
    n = 0;
    while (txrdy === 1'b0 && n < 300) begin tick(); n++; end
    chk("nstop1_txrdy_low_cycles", n, 11 * DIV);
    wait_rxvalid("nstop1_rx_timeout", 50);
    chk("nstop1_rx_q", q, exp_q.pop_front());
    read_pulse();
    tick(2 * DIV);

    // framing error followed by a held break
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    tick(2 * DIV);
    drive_frame(8'hFF, 1'b0);
    wait_rxvalid("fe_timeout", 30);
    chk("fe_q", q, 8'hFF);
    chk("fe_flag", rxframeer, 1);
    read_pulse();
    chk("fe_rd_clears", rxframeer, 0);
    seen = 0;
    for (int i = 0; i < 20 * DIV; i++) begin
      if (rxvalid === 1'b1) seen++;
      tick();
    end
    chk("break_no_rx", seen, 0);
    rxd_drv = 1'b1;
    tick(2 * DIV);
    drive_frame(8'h5A, 1'b1);
    wait_rxvalid("after_break_timeout", 30);
    chk("after_break_q", q, 8'h5A);
    chk("after_break_frameer", rxframeer, 0);
    read_pulse();

    // 2-cycle glitch must not start a reception
    tick(DIV);
    rxd_drv = 1'b0;
    tick(2);
    rxd_drv = 1'b1;
    seen = 0;
    for (int i = 0; i < 15 * DIV; i++) begin
      if (rxvalid !== 1'b0 || rxoverr !== 1'b0 || rxframeer !== 1'b0) seen++;
      tick();
    end
    chk("glitch_no_flags", seen, 0);

    // reset in mid-frame
    loop_en = 1'b1;
    send(8'hC3, 1'b0);
    tick(30);
    reset = 1'b1;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_txrdy", txrdy, 1);
    tick(2);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15 * DIV; i++) begin
      if (rxvalid !== 1'b0 || txd !== 1'b1) seen++;
      tick();
    end
    chk("midrst_quiet", seen, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
